// File: rtl/sonata_pkg.sv
// Shared types for the RGB LED transmit/receive path.
// Pixel layout is GRB, matching the LED wire order.
package sonata_pkg;

  typedef enum logic [2:0] {
    WAIT_RESET = 3'd0,
    ARMED      = 3'd1,
    HIGH       = 3'd2,
    LOW        = 3'd3,
    FORWARD    = 3'd4
  } rgbled_rx_state_e;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgbled_pixel_t;

  function automatic int unsigned ns_to_cycles(
    input int unsigned clk_hz,
    input int unsigned ns
  );
    return ns / (32'd1_000_000_000 / clk_hz);
  endfunction

endpackage

// File: rtl/rgbled_rx_edge.sv
// Two-flop synchroniser for the LED wire plus edge detection
// on the synchronised level.
module rgbled_rx_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din_i;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;

endmodule

// File: rtl/rgbled_rx.sv
// WS2812-style receiver: decodes its own GRB pixel, forwards
// the rest of the frame, and flags latch and protocol errors.
module rgbled_rx
  import sonata_pkg::*;
#(
  parameter int unsigned SysClkFreq  = 40_000_000,
  parameter int unsigned BitThreshNs = 600,
  parameter int unsigned MinHighNs   = 100,
  parameter int unsigned MaxHighNs   = 5000,
  parameter int unsigned ResetNs     = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        din_i,
  output logic        dout_o,
  output logic [23:0] pixel_o,
  output logic        pixel_valid_o,
  output logic        frame_done_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned ThreshCycles =
    ns_to_cycles(SysClkFreq, BitThreshNs);
  localparam int unsigned MinCycles =
    ns_to_cycles(SysClkFreq, MinHighNs);
  localparam int unsigned MaxCycles =
    ns_to_cycles(SysClkFreq, MaxHighNs);
  localparam int unsigned ResetCycles =
    ns_to_cycles(SysClkFreq, ResetNs);
  localparam int unsigned CntW = $clog2(ResetCycles + 1);

  localparam logic [CntW-1:0] CntThresh = CntW'(ThreshCycles);
  localparam logic [CntW-1:0] CntMin    = CntW'(MinCycles);
  localparam logic [CntW-1:0] CntMax    = CntW'(MaxCycles);
  localparam logic [CntW-1:0] CntReset  = CntW'(ResetCycles);

  logic             sync;
  logic             rise;
  logic             fall;
  logic [CntW-1:0]  cnt;
  logic [4:0]       idx;
  logic [23:0]      shift;
  rgbled_pixel_t    pixel;
  rgbled_rx_state_e state;
  logic             low_done;
  logic             bit_val;

  rgbled_rx_edge u_edge (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .din_i (din_i),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  // cnt holds the length of the current level including the edge cycle,
  // so on a fall it equals the number of high cycles seen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (rise | fall) begin
      cnt <= CntW'(1);
    end else if (cnt < CntReset) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign low_done = ~sync & ~fall & (cnt >= CntReset);
  assign bit_val  = (cnt >= CntThresh);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= WAIT_RESET;
      idx           <= '0;
      shift         <= '0;
      pixel         <= '0;
      dout_o        <= 1'b0;
      pixel_valid_o <= 1'b0;
      frame_done_o  <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      dout_o        <= 1'b0;
      pixel_valid_o <= 1'b0;
      frame_done_o  <= 1'b0;
      err_o         <= 1'b0;
      unique case (state)
        WAIT_RESET: begin
          idx <= '0;
          if (low_done) state <= ARMED;
        end
        ARMED: begin
          idx <= '0;
          if (rise) state <= HIGH;
        end
        HIGH: begin
          if (cnt >= CntMax) begin
            err_o <= 1'b1;
            state <= WAIT_RESET;
          end else if (fall) begin
            if (cnt < CntMin) begin
              err_o <= 1'b1;
              state <= WAIT_RESET;
            end else begin
              shift <= {shift[22:0], bit_val};
              idx   <= idx + 1'b1;
              state <= LOW;
            end
          end
        end
        LOW: begin
          if (idx == 5'd24) begin
            pixel         <= shift;
            pixel_valid_o <= 1'b1;
            idx           <= '0;
            state         <= FORWARD;
          end else if (rise) begin
            state <= HIGH;
          end else if (low_done) begin
            err_o <= 1'b1;
            idx   <= '0;
            state <= ARMED;
          end
        end
        FORWARD: begin
          if (low_done) begin
            frame_done_o <= 1'b1;
            state        <= ARMED;
          end else begin
            dout_o <= sync;
          end
        end
        default: state <= WAIT_RESET;
      endcase
    end
  end

  assign pixel_o = pixel;
  assign busy_o  = (state != WAIT_RESET) && (state != ARMED);

endmodule

// File: tb/tb_rgbled_rx.sv
// Directed bench for rgbled_rx: decode, chain forwarding,
// width limits, partial pixels, lock-on and async reset.
module tb_rgbled_rx;

  logic        clk;
  logic        rst;
  logic        din;
  logic        dout;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic        frame_done;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int npv = 0;
  int nfd = 0;
  int nerr = 0;
  int ndout = 0;
  int pv_cyc = 0;
  int err_cyc = 0;
  int last_fall = 0;
  int run = 0;
  logic din_q = 1'b0;
  logic dout_q = 1'b0;
  int diq[$];
  int doq[$];
  int dwq[$];

  rgbled_rx dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .din_i         (din),
    .dout_o        (dout),
    .pixel_o       (pixel),
    .pixel_valid_o (pixel_valid),
    .frame_done_o  (frame_done),
    .err_o         (err),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (pixel_valid) begin
      npv++;
      pv_cyc = cyc;
    end
    if (frame_done) nfd++;
    if (err) begin
      nerr++;
      err_cyc = cyc;
    end
    if (dout) ndout++;
    if (din && !din_q) diq.push_back(cyc);
    if (!din && din_q) last_fall = cyc;
    if (dout && !dout_q) doq.push_back(cyc);
    if (dout) run++;
    else if (dout_q) begin
      dwq.push_back(run);
      run = 0;
    end
    din_q = din;
    dout_q = dout;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic seg(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [23:0] v, input int n,
                           input int h1, input int l1,
                           input int h0, input int l0);
    for (int i = 23; i >= 24 - n; i--) begin
      if (v[i]) begin
        seg(1'b1, h1);
        seg(1'b0, l1);
      end else begin
        seg(1'b1, h0);
        seg(1'b0, l0);
      end
    end
  endtask

  task automatic send_px(input logic [23:0] v);
    send_bits(v, 24, 32, 18, 16, 34);
  endtask

  int b_pv, b_fd, b_err, b_do, b_di, b_doq, b_dw;
  logic [23:0] v2;

  initial begin
    rst = 1'b1;
    din = 1'b0;
    #1;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_pixel", 32'(pixel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pv", 32'(pixel_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_fd", 32'(frame_done), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // single pixel
    b_pv = npv; b_fd = nfd; b_err = nerr; b_do = ndout;
    seg(1'b0, 2100);
    send_px(24'h123456);
    seg(1'b0, 2100);
    chk("p1_pv", 32'(npv - b_pv), 1);
    chk("p1_pixel", 32'(pixel), 32'h123456);
    chk("p1_fd", 32'(nfd - b_fd), 1);
    chk("p1_err", 32'(nerr - b_err), 0);
    chk("p1_dout", 32'(ndout - b_do), 0);
    chk("p1_lat", 32'(pv_cyc - last_fall), 4);

    // two-pixel chain
    b_pv = npv; b_fd = nfd; b_err = nerr;
    b_di = diq.size(); b_doq = doq.size(); b_dw = dwq.size();
    v2 = 24'h00AA55;
    send_px(24'hFF0000);
    send_px(v2);
    seg(1'b0, 2100);
    chk("ch_pixel", 32'(pixel), 32'hFF0000);
    chk("ch_pv", 32'(npv - b_pv), 1);
    chk("ch_fd", 32'(nfd - b_fd), 1);
    chk("ch_err", 32'(nerr - b_err), 0);
    chk("ch_nrise", 32'(doq.size() - b_doq), 24);
    chk("ch_nwid", 32'(dwq.size() - b_dw), 24);
    if (doq.size() - b_doq == 24 && dwq.size() - b_dw == 24 &&
        diq.size() - b_di == 48) begin
      for (int i = 0; i < 24; i++) begin
        chk("ch_dly", 32'(doq[b_doq+i] - diq[b_di+24+i]), 3);
        chk("ch_wid", 32'(dwq[b_dw+i]), v2[23-i] ? 32 : 16);
      end
    end else begin
      chk("ch_queues", 32'(diq.size() - b_di), 48);
    end

    // threshold 23 -> 0, 24 -> 1
    b_err = nerr;
    send_bits(24'hA5C33C, 24, 24, 26, 23, 27);
    seg(1'b0, 2100);
    chk("th_pixel", 32'(pixel), 32'hA5C33C);
    chk("th_err", 32'(nerr - b_err), 0);

    // glitch of 3 cycles, then no lock until a fresh latch
    b_pv = npv; b_err = nerr; b_fd = nfd;
    seg(1'b1, 3);
    seg(1'b0, 30);
    send_px(24'h111111);
    seg(1'b0, 30);
    chk("gl_err", 32'(nerr - b_err), 1);
    chk("gl_pv", 32'(npv - b_pv), 0);
    seg(1'b0, 2100);
    send_px(24'h654321);
    seg(1'b0, 2100);
    chk("gl_pixel", 32'(pixel), 32'h654321);
    chk("gl_pv2", 32'(npv - b_pv), 1);
    chk("gl_fd", 32'(nfd - b_fd), 1);

    // 200-cycle high is too long
    b_pv = npv; b_err = nerr;
    seg(1'b1, 200);
    seg(1'b0, 2100);
    chk("mx_err", 32'(nerr - b_err), 1);
    chk("mx_pv", 32'(npv - b_pv), 0);

    // partial pixel
    b_pv = npv; b_err = nerr; b_fd = nfd;
    send_bits(24'hFFC000, 10, 32, 18, 16, 34);
    seg(1'b0, 2100);
    chk("pp_err", 32'(nerr - b_err), 1);
    chk("pp_lat", 32'(err_cyc - last_fall), 2003);
    chk("pp_pv", 32'(npv - b_pv), 0);
    chk("pp_fd", 32'(nfd - b_fd), 0);
    chk("pp_pixel", 32'(pixel), 32'h654321);
    chk("pp_busy", 32'(busy), 0);
    send_px(24'h0F0F0F);
    seg(1'b0, 2100);
    chk("pp_next", 32'(pixel), 32'h0F0F0F);

    // reset while forwarding a high level
    send_px(24'h222222);
    seg(1'b1, 10);
    chk("rf_busy", 32'(busy), 1);
    chk("rf_dout", 32'(dout), 1);
    rst = 1'b1;
    #1;
    chk("rf_dout0", 32'(dout), 0);
    chk("rf_busy0", 32'(busy), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // mid-stream start: no lock until a latch low
    b_pv = npv;
    seg(1'b1, 15);
    seg(1'b0, 30);
    send_px(24'hABCDEF);
    send_px(24'h987654);
    seg(1'b0, 40);
    chk("lk_pv", 32'(npv - b_pv), 0);
    chk("lk_busy", 32'(busy), 0);
    seg(1'b0, 2100);
    send_px(24'h13579B);
    seg(1'b0, 2100);
    chk("lk_pv2", 32'(npv - b_pv), 1);
    chk("lk_pixel", 32'(pixel), 32'h13579B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
